mips_cpu_muldiv: RTL and testbench

//  Parametrised iterative multiply/divide unit owning the HI/LO register pair for the multicycle MIPS core.

---
 rtl/mips_cpu_pkg.sv | 27 ++
 rtl/mips_cpu_muldiv_if.sv | 30 +++
 rtl/mips_cpu_div_step.sv | 21 ++
 rtl/mips_cpu_muldiv.sv | 148 ++++++++++++++
 tb/tb_mips_cpu_muldiv.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_cpu_pkg.sv
// Shared types and funct constants for the multicycle MIPS core and its mul/div unit.
package mips_cpu_pkg;

    // Operation select, equal to funct[1:0] of the MULT/MULTU/DIV/DIVU encodings
    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } muldiv_op_t;

    // Mul/div sequencer state
    typedef logic [1:0] muldiv_state_t;
    localparam muldiv_state_t ST_IDLE   = 2'd0;
    localparam muldiv_state_t ST_MUL    = 2'd1;
    localparam muldiv_state_t ST_DIV    = 2'd2;
    localparam muldiv_state_t ST_FINISH = 2'd3;

    // R-type funct codes, shared with the core decoder
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

endpackage

// File: rtl/mips_cpu_muldiv_if.sv
// Core <-> mul/div unit bus: operation issue, MTHI/MTLO writes, status and HI/LO readback.
interface mips_cpu_muldiv_if
    import mips_cpu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    muldiv_op_t       op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             hi_write;
    logic             lo_write;
    logic [WIDTH-1:0] write_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // Core side
    modport master (
        output start, op, operand_a, operand_b, hi_write, lo_write, write_data,
        input  busy, done, hi, lo
    );

    // Mul/div unit side
    modport slave (
        input  start, op, operand_a, operand_b, hi_write, lo_write, write_data,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mips_cpu_div_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module mips_cpu_div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             dbit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             quot_bit_o
);
    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    // Partial remainder is always below the divisor, so the shifted trial fits WIDTH+1 bits
    always_comb begin
        trial      = {rem_i, dbit_i};
        diff       = trial - {1'b0, divisor_i};
        quot_bit_o = (trial >= {1'b0, divisor_i});
        rem_o      = quot_bit_o ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    end
endmodule

// File: rtl/mips_cpu_muldiv.sv
// Iterative multiply/divide unit owning HI/LO. Works on operand magnitudes and sign-corrects
// in the FINISH state. Define MIPS_MULDIV_FAST_MULT_EN for a single-cycle multiplier.
module mips_cpu_muldiv
    import mips_cpu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clk_enable,
    mips_cpu_muldiv_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam int unsigned PW    = 2 * WIDTH;

    muldiv_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    acc_q, acc_d;    // mul: {partial, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0] b_q, b_d;        // |operand_b|
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic             is_div_q, is_div_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    logic             is_signed, sign_a, sign_b;
    logic [WIDTH-1:0] div_rem;
    logic             div_qbit;
    logic [PW-1:0]    prod_fix;
    logic [WIDTH-1:0] quot_fix, rem_fix;
`ifndef MIPS_MULDIV_FAST_MULT_EN
    logic [WIDTH:0]   mul_sum;
`endif

    mips_cpu_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_i      (acc_q[PW-1:WIDTH]),
        .dbit_i     (acc_q[WIDTH-1]),
        .divisor_i  (b_q),
        .rem_o      (div_rem),
        .quot_bit_o (div_qbit)
    );

    // Operand sign decode and result sign correction
    always_comb begin
        is_signed = ~bus.op[0];
        sign_a    = is_signed & bus.operand_a[WIDTH-1];
        sign_b    = is_signed & bus.operand_b[WIDTH-1];
        prod_fix  = neg_res_q ? -acc_q : acc_q;
        quot_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix   = neg_rem_q ? -acc_q[PW-1:WIDTH] : acc_q[PW-1:WIDTH];
`ifndef MIPS_MULDIV_FAST_MULT_EN
        mul_sum   = {1'b0, acc_q[PW-1:WIDTH]} + {1'b0, (acc_q[0] ? b_q : '0)};
`endif
    end

    // Sequencer next-state
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        b_d       = b_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        is_div_d  = is_div_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    acc_d     = {{WIDTH{1'b0}}, (sign_a ? -bus.operand_a : bus.operand_a)};
                    b_d       = sign_b ? -bus.operand_b : bus.operand_b;
                    neg_res_d = sign_a ^ sign_b;
                    neg_rem_d = sign_a;
                    is_div_d  = bus.op[1];
                    cnt_d     = CNT_W'(WIDTH - 1);
                    state_d   = bus.op[1] ? ST_DIV : ST_MUL;
                end else begin
                    if (bus.hi_write) hi_d = bus.write_data;
                    if (bus.lo_write) lo_d = bus.write_data;
                end
            end
            ST_MUL: begin
`ifdef MIPS_MULDIV_FAST_MULT_EN
                acc_d   = PW'(acc_q[WIDTH-1:0]) * PW'(b_q);
                state_d = ST_FINISH;
`else
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                if (cnt_q == '0) state_d = ST_FINISH;
                else             cnt_d   = cnt_q - 1'b1;
`endif
            end
            ST_DIV: begin
                acc_d = {div_rem, acc_q[WIDTH-2:0], div_qbit};
                if (cnt_q == '0) state_d = ST_FINISH;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_FINISH: begin
                if (is_div_q) begin
                    // Divide by zero: quotient all ones; remainder already reconstructs operand_a
                    lo_d = (b_q == '0) ? '1 : quot_fix;
                    hi_d = rem_fix;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; clk_enable low freezes everything, including done
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            b_q       <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            is_div_q  <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else if (clk_enable) begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            b_q       <= b_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            is_div_q  <= is_div_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    // Status and HI/LO outputs
    always_comb begin
        bus.busy = (state_q != ST_IDLE);
        bus.done = done_q;
        bus.hi   = hi_q;
        bus.lo   = lo_q;
    end
endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Randomized self-checking bench for mips_cpu_muldiv (WIDTH=32) against a plain-arithmetic model.
module tb_mips_cpu_muldiv;
    import mips_cpu_pkg::*;

    logic clk;
    logic reset_n;
    logic clk_enable;
    int   n_checks = 0;
    int   n_fail   = 0;

    mips_cpu_muldiv_if #(.WIDTH(32)) bus ();

    mips_cpu_muldiv #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clk_enable (clk_enable),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference result {HI, LO} from the arithmetic definition of each op
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] r;
        int          sa;
        int          sb;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            2'b00: r = longint'(sa) * longint'(sb);
            2'b01: r = {32'd0, a} * {32'd0, b};
            2'b10: begin
                if (b == 32'd0)                                  r = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
                else r = {32'(sa % sb), 32'(sa / sb)};
            end
            default: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else            r = {a % b, a / b};
            end
        endcase
        return r;
    endfunction

    function automatic int base_latency(input logic [1:0] op);
`ifdef MIPS_MULDIV_FAST_MULT_EN
        if (!op[1]) return 2;
`endif
        return 33;
    endfunction

    // Present start for one edge; returns at the negedge following the accepting edge
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.op        = muldiv_op_t'(op);
        bus.operand_a = a;
        bus.operand_b = b;
        @(negedge clk);
        bus.start     = 1'b0;
    endtask

    // Count edges after the accepting edge until done; optionally drop clk_enable for 5 edges
    task automatic wait_done(input int pause_at, output int n);
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (pause_at >= 0 && n == pause_at)     clk_enable = 1'b0;
            if (pause_at >= 0 && n == pause_at + 5) clk_enable = 1'b1;
            if (bus.done) break;
        end
        clk_enable = 1'b1;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int pause_at, input string tag);
        int n;
        int lat;
        lat = base_latency(op) + ((pause_at >= 0) ? 5 : 0);
        issue(op, a, b);
        check({tag, "/busy"}, 64'(bus.busy), 64'd1);
        wait_done(pause_at, n);
        check({tag, "/lat"}, 64'(n), 64'(lat));
        check({tag, "/res"}, {bus.hi, bus.lo}, model(op, a, b));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'd1;
            4:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        reset_n        = 1'b0;
        clk_enable     = 1'b1;
        bus.start      = 1'b0;
        bus.op         = OP_MULT;
        bus.operand_a  = '0;
        bus.operand_b  = '0;
        bus.hi_write   = 1'b0;
        bus.lo_write   = 1'b0;
        bus.write_data = '0;
        #2;
        check("rst/busy", 64'(bus.busy), 64'd0);
        check("rst/done", 64'(bus.done), 64'd0);
        check("rst/hilo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Directed cases
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, "multu_max");
        check("multu_max/exact", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, -1, "mult_neg");
        check("mult_neg/exact", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, -1, "mult_min");
        check("mult_min/exact", {bus.hi, bus.lo}, 64'h4000_0000_0000_0000);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, -1, "div_neg");
        check("div_neg/exact", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(2'b11, 32'd7, 32'd2, -1, "divu");
        check("divu/exact", {bus.hi, bus.lo}, 64'h0000_0001_0000_0003);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1, "div_ovf");
        check("div_ovf/exact", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);
        run_op(2'b11, 32'd5, 32'd0, -1, "divu_z");
        check("divu_z/exact", {bus.hi, bus.lo}, 64'h0000_0005_FFFF_FFFF);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd0, -1, "div_z");
        check("div_z/exact", {bus.hi, bus.lo}, 64'hFFFF_FFF9_FFFF_FFFF);

        // MTHI / MTLO in idle
        @(negedge clk);
        bus.hi_write   = 1'b1;
        bus.write_data = 32'h1234_5678;
        @(negedge clk);
        bus.hi_write   = 1'b0;
        check("mthi", 64'(bus.hi), 64'h1234_5678);
        bus.lo_write   = 1'b1;
        bus.write_data = 32'h9ABC_DEF0;
        @(negedge clk);
        bus.lo_write   = 1'b0;
        check("mtlo", {bus.hi, bus.lo}, 64'h1234_5678_9ABC_DEF0);

        // Writes and a second start while busy are ignored
        issue(2'b01, 32'd3, 32'd5);
        bus.hi_write   = 1'b1;
        bus.lo_write   = 1'b1;
        bus.write_data = 32'hDEAD_BEEF;
        bus.start      = 1'b1;
        bus.op         = OP_DIVU;
        bus.operand_a  = 32'd100;
        bus.operand_b  = 32'd7;
        @(negedge clk);
        check("busy_wr", {bus.hi, bus.lo}, 64'h1234_5678_9ABC_DEF0);
        bus.hi_write = 1'b0;
        bus.lo_write = 1'b0;
        bus.start    = 1'b0;
        wait_done(-1, n);
        check("busy_restart/lat", 64'(n + 1), 64'(base_latency(2'b01)));
        check("busy_restart/res", {bus.hi, bus.lo}, 64'd15);

        // Start wins over a simultaneous MTHI/MTLO
        @(negedge clk);
        bus.start      = 1'b1;
        bus.op         = OP_MULTU;
        bus.operand_a  = 32'hFFFF_FFFF;
        bus.operand_b  = 32'd3;
        bus.hi_write   = 1'b1;
        bus.lo_write   = 1'b1;
        bus.write_data = 32'h5555_AAAA;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.hi_write = 1'b0;
        bus.lo_write = 1'b0;
        check("start_prio", {bus.hi, bus.lo}, 64'd15);
        wait_done(-1, n);
        check("start_prio/res", {bus.hi, bus.lo}, 64'h0000_0002_FFFF_FFFD);

        // Async reset mid-divide
        issue(2'b11, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort/busy", 64'(bus.busy), 64'd0);
        check("abort/hilo", {bus.hi, bus.lo}, 64'd0);
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) n++;
        end
        check("abort/nodone", 64'(n), 64'd0);
        reset_n = 1'b1;
        run_op(2'b10, 32'd1000, 32'hFFFF_FFFD, -1, "post_rst");

        // clk_enable pause mid-multiply
        run_op(2'b01, 32'h0001_2345, 32'h0000_BEEF, 1, "pause");

        // done holds while disabled, clears on the next enabled edge
        issue(2'b11, 32'd99, 32'd10);
        wait_done(-1, n);
        clk_enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("done_hold", 64'(bus.done), 64'd1);
        clk_enable = 1'b1;
        @(negedge clk);
        check("done_clear", 64'(bus.done), 64'd0);

        // Random operations
        for (int i = 0; i < 60; i++) begin
            logic [1:0] op;
            op = 2'($urandom_range(0, 3));
            run_op(op, pick(), pick(), ($urandom_range(0, 9) == 0) ? 1 : -1,
                   $sformatf("rnd%0d_op%0d", i, op));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
